// File: rtl/lms_pkg.sv
// Shared types for the LMS datapath monitors: FSM encodings and accumulator sizing.
package lms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_CONV  = 2'd2
    } lms_state_t;

    // Sum of 2^wl squares of dw-bit samples cannot overflow this width.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned wl);
        return 2 * dw + wl;
    endfunction

endpackage

// File: rtl/lms_err_sq.sv
// Registered signed squarer with valid pass-through; result is the unsigned square.
module lms_err_sq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic signed [DATA_WIDTH-1:0]  err_in,
    input  logic                          err_valid,
    output logic [2*DATA_WIDTH-1:0]       sq_out,
    output logic                          sq_valid
);

    logic signed [2*DATA_WIDTH-1:0] err_ext;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign err_ext = $signed({{DATA_WIDTH{err_in[DATA_WIDTH-1]}}, err_in});
    // (-2^(W-1))^2 = 2^(2W-2) still fits as an unsigned 2W-bit value.
    assign prod    = err_ext * err_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq_out   <= '0;
            sq_valid <= 1'b0;
        end else if (clear) begin
            sq_out   <= '0;
            sq_valid <= 1'b0;
        end else begin
            sq_valid <= err_valid;
            if (err_valid) sq_out <= $unsigned(prod);
        end
    end

endmodule

// File: rtl/lms_conv_monitor.sv
// Windowed MSE of the LMS error stream with a convergence FSM.
// Optional peak |err| output enabled by defining LMS_CONV_PEAK_EN.
module lms_conv_monitor
    import lms_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIN_LOG2   = 6,
    parameter int unsigned HOLD_WINS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic signed [DATA_WIDTH-1:0]  err_in,
    input  logic                          err_valid,
    input  logic [2*DATA_WIDTH-1:0]       thresh,
    output logic [2*DATA_WIDTH-1:0]       mse_out,
    output logic                          mse_valid,
    output logic                          converged,
    output logic [1:0]                    state_out
`ifdef LMS_CONV_PEAK_EN
    ,
    output logic [DATA_WIDTH-1:0]         peak_out
`endif
);

    localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, WIN_LOG2);
    localparam int unsigned MW        = 2 * DATA_WIDTH;

    logic [MW-1:0]        sq;
    logic                 sq_valid;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] win_sum;
    logic [ACC_WIDTH-1:0] win_mean;
    logic [WIN_LOG2-1:0]  cnt_q;
    logic                 last_sample;

    // Window-close pipeline stage: mean and threshold verdict wait one cycle here.
    logic [MW-1:0]        mse_pipe_q;
    logic                 close_q;
    logic                 good_q;

    lms_state_t           state_q, state_d;
    logic [7:0]           good_cnt_q, good_cnt_d;

    lms_err_sq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sq (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .err_in    (err_in),
        .err_valid (err_valid),
        .sq_out    (sq),
        .sq_valid  (sq_valid)
    );

    assign last_sample = sq_valid && (&cnt_q);
    assign win_sum     = acc_q + {{WIN_LOG2{1'b0}}, sq};
    assign win_mean    = win_sum >> WIN_LOG2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            mse_pipe_q <= '0;
            close_q    <= 1'b0;
            good_q     <= 1'b0;
        end else if (clear) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            mse_pipe_q <= '0;
            close_q    <= 1'b0;
            good_q     <= 1'b0;
        end else begin
            close_q <= last_sample;
            if (sq_valid) begin
                if (last_sample) begin
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    mse_pipe_q <= win_mean[MW-1:0];
                    good_q     <= (win_mean[MW-1:0] < thresh);
                end else begin
                    acc_q <= win_sum;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mse_out   <= '0;
            mse_valid <= 1'b0;
        end else if (clear) begin
            mse_out   <= '0;
            mse_valid <= 1'b0;
        end else begin
            mse_valid <= close_q;
            if (close_q) mse_out <= mse_pipe_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            good_cnt_q <= '0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    always_comb begin
        good_cnt_d = good_cnt_q;
        state_d    = state_q;
        if (close_q) begin
            if (!good_q) good_cnt_d = '0;
            else if (good_cnt_q != 8'(HOLD_WINS)) good_cnt_d = good_cnt_q + 8'd1;
        end
        case (state_q)
            ST_IDLE:  if (close_q) state_d = ST_TRACK;
            ST_TRACK: if (close_q && good_cnt_d == 8'(HOLD_WINS)) state_d = ST_CONV;
            ST_CONV:  if (close_q && !good_q) state_d = ST_TRACK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state_out = state_q;
        converged = (state_q == ST_CONV);
    end

`ifdef LMS_CONV_PEAK_EN
    logic [DATA_WIDTH-1:0] abs_q;
    logic [DATA_WIDTH-1:0] pk_acc_q;
    logic [DATA_WIDTH-1:0] pk_pipe_q;
    logic [DATA_WIDTH-1:0] pk_cand;
    logic [DATA_WIDTH-1:0] abs_in;

    // The most negative sample saturates to the largest positive magnitude.
    always_comb begin
        abs_in = err_in;
        if (err_in[DATA_WIDTH-1]) begin
            if (err_in == {1'b1, {(DATA_WIDTH-1){1'b0}}}) abs_in = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            else abs_in = -err_in;
        end
    end

    assign pk_cand = (abs_q > pk_acc_q) ? abs_q : pk_acc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abs_q     <= '0;
            pk_acc_q  <= '0;
            pk_pipe_q <= '0;
            peak_out  <= '0;
        end else if (clear) begin
            abs_q     <= '0;
            pk_acc_q  <= '0;
            pk_pipe_q <= '0;
            peak_out  <= '0;
        end else begin
            if (err_valid) abs_q <= abs_in;
            if (sq_valid) begin
                if (last_sample) begin
                    pk_pipe_q <= pk_cand;
                    pk_acc_q  <= '0;
                end else begin
                    pk_acc_q <= pk_cand;
                end
            end
            if (close_q) peak_out <= pk_pipe_q;
        end
    end
`endif

endmodule
